// File: rtl/acc_reduce_pkg.sv
// acc_reduce_pkg
// Shared definitions for the acc_reduce streaming reduction stage:
//   - FSM state encoding (ACCUM collects a group, EMIT holds a finished sum)
//   - cnt_width(): width of the in-group element counter for a given COUNT
package acc_reduce_pkg;

  localparam logic ACC_ST_ACCUM = 1'b0;
  localparam logic ACC_ST_EMIT  = 1'b1;

  typedef enum logic {
    ST_ACCUM = ACC_ST_ACCUM,
    ST_EMIT  = ACC_ST_EMIT
  } acc_state_e;

  // Counter width for COUNT elements; never narrower than one bit (COUNT == 1).
  function automatic int cnt_width(input int count);
    int w;
    w = $clog2(count);
    if (w < 32'sd1) begin
      return 32'sd1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/acc_reduce_if.sv
// acc_reduce_if
// Stream interface of acc_reduce: product input stream and sum output stream.
//   ins / ins_valid / ins_ready    : product stream into the reducer
//   outs / outs_valid / outs_ready : group-sum stream out of the reducer
// Modports:
//   master : the environment (drives products, accepts sums)
//   slave  : the reducer itself
interface acc_reduce_if #(
  parameter int DATA_TYPE = 32
);

  logic [DATA_TYPE-1:0] ins;
  logic                 ins_valid;
  logic                 ins_ready;
  logic [DATA_TYPE-1:0] outs;
  logic                 outs_valid;
  logic                 outs_ready;

  modport master (
    output ins, ins_valid, outs_ready,
    input  ins_ready, outs, outs_valid
  );

  modport slave (
    input  ins, ins_valid, outs_ready,
    output ins_ready, outs, outs_valid
  );

endinterface

// File: rtl/acc_group_counter.sv
// acc_group_counter
// Modulo-COUNT element counter for the reducer.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (counter to 0)
//   en   : advance by one (one accepted product)
//   cnt  : index of the next element within the current group
//   last : cnt == COUNT-1, i.e. the next accepted element closes the group
module acc_group_counter
  import acc_reduce_pkg::*;
#(
  parameter int COUNT = 8,
  parameter int CNT_W = cnt_width(COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COUNT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Element counter: wraps to zero after the last element of a group.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (en) begin
      if (cnt_r == CNT_MAX) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign last = (cnt_r == CNT_MAX);

endmodule

// File: rtl/acc_reduce.sv
// acc_reduce
// Streaming reduction stage: sums COUNT consecutive products (modulo
// 2^DATA_TYPE) and emits one sum per group over a valid/ready handshake.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset; drops any partial or pending sum
//   bus : acc_reduce_if.slave (ins/ins_valid/ins_ready, outs/outs_valid/outs_ready)
// Build option:
//   ACC_REDUCE_OVERLAP_EN : when defined, an input may be accepted in the same
//   cycle the finished sum leaves (ins_ready follows outs_ready in EMIT), giving
//   one product per cycle with no bubble between groups. When undefined, EMIT
//   holds ins_ready low and each group costs one bubble cycle.
module acc_reduce
  import acc_reduce_pkg::*;
#(
  parameter int DATA_TYPE = 32,
  parameter int COUNT     = 8
) (
  input  logic         clk,
  input  logic         rst,
  acc_reduce_if.slave  bus
);

  localparam int CNT_W = cnt_width(COUNT);

  acc_state_e           state_r;
  acc_state_e           state_nxt_s;
  logic [DATA_TYPE-1:0] acc_r;
  logic [DATA_TYPE-1:0] acc_nxt_s;
  logic                 outs_valid_r;
  logic [CNT_W-1:0]     cnt_s;
  logic                 last_s;
  logic                 first_s;
  logic                 ins_ready_s;
  logic                 in_xfer_s;
  logic                 out_xfer_s;

  acc_group_counter #(
    .COUNT (COUNT),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (in_xfer_s),
    .cnt  (cnt_s),
    .last (last_s)
  );

  // The counter sits at zero both at a group start and while EMIT is held,
  // so an overlapped accept in EMIT is naturally treated as a first element.
  assign first_s    = (cnt_s == '0);
  assign in_xfer_s  = bus.ins_valid && ins_ready_s;
  assign out_xfer_s = outs_valid_r && bus.outs_ready;

  // Input ready: open while collecting, closed (or following outs_ready) in EMIT.
  always_comb begin
    ins_ready_s = 1'b0;
    if (rst) begin
      ins_ready_s = 1'b0;
    end else begin
      case (state_r)
        ST_ACCUM: ins_ready_s = 1'b1;
`ifdef ACC_REDUCE_OVERLAP_EN
        ST_EMIT:  ins_ready_s = bus.outs_ready;
`else
        ST_EMIT:  ins_ready_s = 1'b0;
`endif
        default:  ins_ready_s = 1'b0;
      endcase
    end
  end

  // Accumulator update: load on the first element, wrap-around add after.
  always_comb begin
    acc_nxt_s = acc_r;
    if (in_xfer_s) begin
      if (first_s) begin
        acc_nxt_s = bus.ins;
      end else begin
        acc_nxt_s = acc_r + bus.ins;
      end
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  // Next-state logic; EMIT re-entered directly only when an overlapped
  // accept closes a group at once (COUNT == 1).
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_ACCUM: begin
        if (in_xfer_s && last_s) begin
          state_nxt_s = ST_EMIT;
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_EMIT: begin
        if (out_xfer_s) begin
          if (in_xfer_s && last_s) begin
            state_nxt_s = ST_EMIT;
          end else begin
            state_nxt_s = ST_ACCUM;
          end
        end else begin
          state_nxt_s = ST_EMIT;
        end
      end
      default: state_nxt_s = ST_ACCUM;
    endcase
  end

  // State, accumulator and registered output-valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_ACCUM;
      acc_r        <= '0;
      outs_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      acc_r        <= acc_nxt_s;
      outs_valid_r <= (state_nxt_s == ST_EMIT);
    end
  end

  assign bus.ins_ready  = ins_ready_s;
  assign bus.outs       = acc_r;
  assign bus.outs_valid = outs_valid_r;

endmodule
